// File: rtl/mic1_run_ctrl_if.sv
// Core-facing signals of the MIC-1 run controller: clock enable out, boundary/halt in.
// Breakpoint signals are present only when MIC1_RUN_CTRL_BREAK_EN is defined.
interface mic1_run_ctrl_if;
  logic        instr_boundary;
  logic        cpu_halt;
  logic        cpu_ce;
`ifdef MIC1_RUN_CTRL_BREAK_EN
  logic [11:0] cpu_pc;
  logic [11:0] bp_addr;
  logic        bp_valid;
  logic        bp_hit;

  modport master (
    input  instr_boundary,
    input  cpu_halt,
    input  cpu_pc,
    input  bp_addr,
    input  bp_valid,
    output cpu_ce,
    output bp_hit
  );

  modport slave (
    output instr_boundary,
    output cpu_halt,
    output cpu_pc,
    output bp_addr,
    output bp_valid,
    input  cpu_ce,
    input  bp_hit
  );
`else
  modport master (
    input  instr_boundary,
    input  cpu_halt,
    output cpu_ce
  );

  modport slave (
    output instr_boundary,
    output cpu_halt,
    input  cpu_ce
  );
`endif
endinterface

// File: rtl/mic1_run_ctrl.sv
// Run/step/stop sequencer for the MIC-1 core: button conditioning, clock-enable FSM, cycle counter.
// Optional breakpoint stop in RUN is enabled by defining MIC1_RUN_CTRL_BREAK_EN.
module mic1_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_stop,
  mic1_run_ctrl_if.master  core,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             run_led,
  output logic             halt_led
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_RUN     = 2'b01,
    ST_STEP    = 2'b10,
    ST_HALTED  = 2'b11
  } state_t;

  // Button index: 0 run, 1 step, 2 stop.
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      stable_q, stable_d;
  logic [2:0]      press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];

  assign btn_raw = {btn_stop, btn_step, btn_run};

  // The counter counts consecutive samples that disagree with the accepted level.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      press_d[i]  = 1'b0;
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
          press_d[i]  = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  logic stop_p, step_p, run_p;

  assign stop_p = press_q[2];
  assign step_p = press_q[1] & ~press_q[2];
  assign run_p  = press_q[0] & ~press_q[1] & ~press_q[2];

  state_t           state_q, state_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic             run_led_q, run_led_d;
  logic             halt_led_q, halt_led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_now, bound_now;

  assign halt_now  = core.cpu_halt & cpu_ce_q;
  assign bound_now = core.instr_boundary & cpu_ce_q;

`ifdef MIC1_RUN_CTRL_BREAK_EN
  logic bp_now;
  logic bp_hit_q, bp_hit_d;

  assign bp_now = bound_now & core.bp_valid & (core.cpu_pc == core.bp_addr);
`endif

  always_comb begin
    state_d = state_q;
`ifdef MIC1_RUN_CTRL_BREAK_EN
    bp_hit_d = 1'b0;
`endif
    case (state_q)
      ST_STOPPED: begin
        if (run_p) begin
          state_d = ST_RUN;
        end else if (step_p) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_now) begin
          state_d = ST_HALTED;
`ifdef MIC1_RUN_CTRL_BREAK_EN
        end else if (bp_now) begin
          state_d  = ST_STOPPED;
          bp_hit_d = 1'b1;
`endif
        end else if (stop_p) begin
          state_d = ST_STEP;
        end
      end
      // STEP and STOPPING share this state: finish the current macroinstruction.
      ST_STEP: begin
        if (halt_now) begin
          state_d = ST_HALTED;
        end else if (bound_now) begin
          state_d = ST_STOPPED;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_STOPPED;
    endcase

    cpu_ce_d   = (state_d == ST_RUN) || (state_d == ST_STEP);
    run_led_d  = (state_d == ST_RUN);
    halt_led_d = (state_d == ST_HALTED);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cpu_ce_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STOPPED;
      cpu_ce_q   <= 1'b0;
      run_led_q  <= 1'b0;
      halt_led_q <= 1'b0;
      cnt_q      <= '0;
`ifdef MIC1_RUN_CTRL_BREAK_EN
      bp_hit_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cpu_ce_q   <= cpu_ce_d;
      run_led_q  <= run_led_d;
      halt_led_q <= halt_led_d;
      cnt_q      <= cnt_d;
`ifdef MIC1_RUN_CTRL_BREAK_EN
      bp_hit_q   <= bp_hit_d;
`endif
    end
  end

  assign core.cpu_ce = cpu_ce_q;
`ifdef MIC1_RUN_CTRL_BREAK_EN
  assign core.bp_hit = bp_hit_q;
`endif
  assign state_o   = state_q;
  assign cycle_cnt = cnt_q;
  assign run_led   = run_led_q;
  assign halt_led  = halt_led_q;

endmodule
